fx_sqrt_seq: RTL and testbench

//  Multi-cycle square root for Q11.21 operands: the inverse of squaring through fxMul.

---
 rtl/fx_sqrt_seq_if.sv | 29 ++
 rtl/fx_sqrt_seq.sv | 180 ++++++++++++++++++
 tb/tb_fx_sqrt_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fx_sqrt_seq_if.sv
// -----------------------------------------------------------------------------
// fx_sqrt_seq_if
//   Handshake bundle for the sequential Q11.21 square-root unit.
//   Operand side : in_valid / in_ready / x
//   Result side  : out_valid / out_ready / result / err
//   master : producer of operands and consumer of results (e.g. a testbench)
//   slave  : the square-root unit itself
// -----------------------------------------------------------------------------
interface fx_sqrt_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, result, err
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, result, err
  );
endinterface

// File: rtl/fx_sqrt_seq.sv
// -----------------------------------------------------------------------------
// fx_sqrt_seq
//   Multi-cycle square root of a signed Qm.f operand (Q11.21 by default).
//   Computes floor(sqrt(x << FRAC_BITS)) with a radix-2 non-restoring integer
//   square root, one result bit per clock, so the result carries the same
//   number of fractional bits as the operand. One operation in flight.
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : fx_sqrt_seq_if.slave
//            in_valid/in_ready/x             operand handshake
//            out_valid/out_ready/result/err  result handshake
//          result is always >= 0; err flags a negative operand (result = 0).
//
// Timing
//   out_valid rises ITER+1 edges after the accept edge (counting the accept
//   edge itself), or on the accept edge for a negative operand. DONE always
//   returns to IDLE through one extra edge, so throughput is one op per
//   ITER+2 cycles.
// -----------------------------------------------------------------------------
module fx_sqrt_seq #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 21
) (
  input  logic          clk,
  input  logic          rst,
  fx_sqrt_seq_if.slave  bus
);

  // Radicand is the operand shifted up by FRAC_BITS, padded to an even width
  // so that it can be consumed two bits per iteration.
  localparam int RAD_RAW = WIDTH + FRAC_BITS;
  localparam int RAD_W   = RAD_RAW + (RAD_RAW % 2);
  localparam int ITER    = RAD_W / 2;
  // The partial remainder never exceeds 2*root+1 before shifting, so ITER+2
  // bits hold the shifted remainder without overflow.
  localparam int REM_W   = ITER + 2;
  localparam int CNT_W   = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t             state_q,  state_d;
  logic [RAD_W-1:0]   rad_q,    rad_d;
  logic [REM_W-1:0]   rem_q,    rem_d;
  logic [ITER-1:0]    root_q,   root_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               err_q,    err_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic               accept;
  logic               x_neg;
  logic [RAD_W-1:0]   rad_load;
  logic [REM_W-1:0]   rem_shift;
  logic [REM_W-1:0]   trial;
  logic               take;
  logic [REM_W-1:0]   rem_sub;
  logic [ITER-1:0]    root_step;
  logic               last_iter;

  assign accept    = bus.in_valid && (state_q == S_IDLE);
  assign x_neg     = bus.x[WIDTH-1];

  // Zero-extend then scale; only reached for non-negative operands.
  assign rad_load  = {{(RAD_W - WIDTH){1'b0}}, bus.x} << FRAC_BITS;

  // Bring down the next two radicand bits and form the trial subtrahend
  // 4*root + 1 for this bit position.
  assign rem_shift = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
  assign trial     = {root_q, 2'b01};
  assign take      = (rem_shift >= trial);
  assign rem_sub   = rem_shift - trial;
  assign root_step = {root_q[ITER-2:0], take};
  assign last_iter = (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rad_d    = rad_q;
    rem_d    = rem_q;
    root_d   = root_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          rem_d    = '0;
          root_d   = '0;
          cnt_d    = '0;
          result_d = '0;
          if (x_neg) begin
            // Negative operand: no iterations, report straight away.
            rad_d   = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            rad_d   = rad_load;
            err_d   = 1'b0;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        rem_d  = take ? rem_sub : rem_shift;
        root_d = root_step;
        rad_d  = {rad_q[RAD_W-3:0], 2'b00};
        if (last_iter) begin
          cnt_d    = '0;
          result_d = {{(WIDTH - ITER){1'b0}}, root_step};
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        // result_q/err_q are untouched here, so they stay stable while the
        // consumer stalls.
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rad_q    <= rad_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
    bus.result    = result_q;
    bus.err       = err_q;
  end

endmodule

// File: tb/tb_fx_sqrt_seq.sv
// -----------------------------------------------------------------------------
// tb_fx_sqrt_seq
//   Bench for fx_sqrt_seq. A behavioural model (integer sqrt of x*2^21 plus
//   the documented latencies) predicts every cycle's handshake outputs; a
//   single negedge process compares the DUT against it. Directed operations
//   additionally check hand-computed literal results and latencies.
// -----------------------------------------------------------------------------
module tb_fx_sqrt_seq;

  localparam int WIDTH   = 32;
  localparam int FRAC    = 21;
  localparam int LAT_POS = 28;
  localparam int LAT_NEG = 1;
  localparam int N_RAND  = 1500;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fx_sqrt_seq_if #(.WIDTH(WIDTH)) bus ();

  fx_sqrt_seq #(.WIDTH(WIDTH), .FRAC_BITS(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // floor(sqrt(v)) via floating point, corrected to the exact integer.
  function automatic longint isqrt(input longint v);
    longint r;
    r = longint'($floor($sqrt(real'(v))));
    while (r * r > v) r--;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic longint model_res(input logic [31:0] xv);
    longint v;
    if (xv[31]) return 0;
    v = longint'(xv) * (longint'(1) << FRAC);
    return isqrt(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Per-cycle model and compare process
  // ---------------------------------------------------------------------------
  typedef struct {
    longint res;
    logic   err;
    int     due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;

  always @(negedge clk) begin
    logic exp_v;
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      chk("rst_in_ready",  longint'(bus.in_ready),  1);
      chk("rst_out_valid", longint'(bus.out_valid), 0);
      chk("rst_result",    longint'(bus.result),    0);
      chk("rst_err",       longint'(bus.err),       0);
    end else begin
      exp_v = (q.size() > 0) && (cyc >= q[0].due);
      chk("in_ready",  longint'(bus.in_ready),  (q.size() == 0) ? 1 : 0);
      chk("out_valid", longint'(bus.out_valid), longint'(exp_v));
      if (exp_v && bus.out_valid) begin
        chk("result", longint'(bus.result), q[0].res);
        chk("err",    longint'(bus.err),    longint'(q[0].err));
        if (bus.out_ready) void'(q.pop_front());
      end
      if (bus.in_valid && bus.in_ready && q.size() == 0) begin
        e.res = model_res(bus.x);
        e.err = bus.x[31];
        e.due = cyc + (bus.x[31] ? LAT_NEG : LAT_POS);
        q.push_back(e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Present an operand and return just after the edge that accepts it.
  task automatic send(input logic [31:0] v);
    int n;
    n = 0;
    bus.x        = v;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Directed op with literal result and latency (accept edge counts as 1).
  task automatic run_dir(input logic [31:0] v, input longint exp_res,
                         input logic exp_err, input int exp_lat);
    int lat;
    send(v);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("dir_latency", lat, exp_lat);
    chk("dir_result", longint'(bus.result), exp_res);
    chk("dir_err", longint'(bus.err), longint'(exp_err));
    $display("op x=0x%08h result=0x%08h err=%0b latency=%0d", v, bus.result, bus.err, lat);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("out_valid_timeout", 1, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] v;
    logic [31:0] held;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.out_ready = 1'b1;

    // Pin the model against hand-computed values.
    chk("model_4p0",  model_res(32'h0080_0000), 64'h0040_0000);
    chk("model_2p0",  model_res(32'h0040_0000), 64'h002D_413C);
    chk("model_lsb",  model_res(32'h0000_0001), 64'h0000_05A8);
    chk("model_max",  model_res(32'h7FFF_FFFF), 64'h03FF_FFFF);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed operations.
    run_dir(32'h0080_0000, 64'h0040_0000, 1'b0, LAT_POS);
    run_dir(32'h0040_0000, 64'h002D_413C, 1'b0, LAT_POS);
    run_dir(32'h0000_0001, 64'h0000_05A8, 1'b0, LAT_POS);
    run_dir(32'h7FFF_FFFF, 64'h03FF_FFFF, 1'b0, LAT_POS);
    run_dir(32'h0000_0000, 64'h0000_0000, 1'b0, LAT_POS);
    run_dir(32'hFFE0_0000, 64'h0000_0000, 1'b1, LAT_NEG);

    // Consumer stall in DONE; an operand pulse meanwhile must be ignored.
    bus.out_ready = 1'b0;
    send(32'h0040_0000);
    wait_out_valid();
    held = bus.result;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("stall_out_valid", longint'(bus.out_valid), 1);
      chk("stall_in_ready",  longint'(bus.in_ready),  0);
      chk("stall_result",    longint'(bus.result),    longint'(held));
      if (i == 3) begin
        bus.x        = 32'h0012_3456;
        bus.in_valid = 1'b1;
      end
      if (i == 5) bus.in_valid = 1'b0;
    end
    $display("op stall x=0x00400000 result=0x%08h held 10 cycles", bus.result);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    // Reset in the middle of the iterations.
    send(32'h0080_0000);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready",  longint'(bus.in_ready),  1);
    chk("midrst_out_valid", longint'(bus.out_valid), 0);
    chk("midrst_result",    longint'(bus.result),    0);
    chk("midrst_err",       longint'(bus.err),       0);
    $display("op reset mid-calc in_ready=%0b out_valid=%0b", bus.in_ready, bus.out_valid);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_dir(32'h0080_0000, 64'h0040_0000, 1'b0, LAT_POS);

    // Randomized back-to-back operations, consumer always ready.
    for (int i = 0; i < N_RAND; i++) begin
      v = $urandom;
      if ($urandom_range(15) != 0) v[31] = 1'b0;
      if ($urandom_range(7) == 0) v = 32'($urandom_range(255));
      send(v);
      if (i % 100 == 0) $display("op rand %0d x=0x%08h expect=0x%08h", i, v, model_res(v));
    end
    wait_out_valid();
    repeat (3) @(posedge clk);
    #1;
    chk("drain", longint'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
